adder_share_arb: RTL

- Two-requester round-robin arbiter and sequencer for a single shared multi-cycle wide adder/subtractor (mpadder).
- Lets two clients share one adder instance, e.g. the 3x-operand precompute path and the Montgomery reduction loop.
- Latches the winner's operands, issues a one-cycle start pulse to the adder, waits for the adder's done, then returns the result with a one-cycle done pulse to the winner.

---
 rtl/adder_share_arb_if.sv | 38 +++
 rtl/adder_share_arb.sv | 124 ++++++++++++
 2 files changed

// File: rtl/adder_share_arb_if.sv
// Signal bundle between two adder clients, the arbiter and the shared multi-cycle adder.
// The slave modport is the arbiter's view; the master modport is the clients/adder side.
interface adder_share_arb_if #(
  parameter int WIDTH = 1027
);
  logic             req0;
  logic [WIDTH-1:0] a0;
  logic [WIDTH-1:0] b0;
  logic             sub0;
  logic             req1;
  logic [WIDTH-1:0] a1;
  logic [WIDTH-1:0] b1;
  logic             sub1;
  logic             grant0;
  logic             grant1;
  logic             done0;
  logic             done1;
  logic [WIDTH-1:0] result;
  logic             busy;
  logic             add_start;
  logic             add_subtract;
  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] add_b;
  logic [WIDTH-1:0] add_result;
  logic             add_done;

  modport master (
    output req0, a0, b0, sub0, req1, a1, b1, sub1, add_result, add_done,
    input  grant0, grant1, done0, done1, result, busy,
           add_start, add_subtract, add_a, add_b
  );

  modport slave (
    input  req0, a0, b0, sub0, req1, a1, b1, sub1, add_result, add_done,
    output grant0, grant1, done0, done1, result, busy,
           add_start, add_subtract, add_a, add_b
  );
endinterface

// File: rtl/adder_share_arb.sv
// Round-robin arbiter/sequencer letting two clients share one multi-cycle adder:
// latch winner's operands, pulse add_start, wait for add_done, return result with a done pulse.
module adder_share_arb #(
  parameter int WIDTH = 1027
) (
  input  logic                clk,
  input  logic                reset,
  adder_share_arb_if.slave    bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  state_e           state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic             grant0_q, grant0_d;
  logic             grant1_q, grant1_d;
  logic             done0_q, done0_d;
  logic             done1_q, done1_d;
  logic             busy_q, busy_d;
  logic             add_start_q, add_start_d;
  logic             add_subtract_q, add_subtract_d;
  logic [WIDTH-1:0] add_a_q, add_a_d;
  logic [WIDTH-1:0] add_b_q, add_b_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             pick1;

  // Requester 1 wins when alone, or on a tie when requester 0 was served last.
  assign pick1 = bus.req1 & (~bus.req0 | ~last_grant_q);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      last_grant_q   <= 1'b1;
      grant0_q       <= 1'b0;
      grant1_q       <= 1'b0;
      done0_q        <= 1'b0;
      done1_q        <= 1'b0;
      busy_q         <= 1'b0;
      add_start_q    <= 1'b0;
      add_subtract_q <= 1'b0;
      add_a_q        <= '0;
      add_b_q        <= '0;
      result_q       <= '0;
    end else begin
      state_q        <= state_d;
      last_grant_q   <= last_grant_d;
      grant0_q       <= grant0_d;
      grant1_q       <= grant1_d;
      done0_q        <= done0_d;
      done1_q        <= done1_d;
      busy_q         <= busy_d;
      add_start_q    <= add_start_d;
      add_subtract_q <= add_subtract_d;
      add_a_q        <= add_a_d;
      add_b_q        <= add_b_d;
      result_q       <= result_d;
    end
  end

  // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (bus.req0 | bus.req1) state_d = ISSUE;
      ISSUE: state_d = WAIT;
      WAIT:  if (bus.add_done) state_d = RESP;
      RESP:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    last_grant_d   = last_grant_q;
    grant0_d       = grant0_q;
    grant1_d       = grant1_q;
    done0_d        = 1'b0;
    done1_d        = 1'b0;
    add_start_d    = 1'b0;
    add_subtract_d = add_subtract_q;
    add_a_d        = add_a_q;
    add_b_d        = add_b_q;
    result_d       = result_q;
    unique case (state_q)
      IDLE: begin
        if (bus.req0 | bus.req1) begin
          grant0_d       = ~pick1;
          grant1_d       = pick1;
          last_grant_d   = pick1;
          add_start_d    = 1'b1;
          add_a_d        = pick1 ? bus.a1 : bus.a0;
          add_b_d        = pick1 ? bus.b1 : bus.b0;
          add_subtract_d = pick1 ? bus.sub1 : bus.sub0;
        end
      end
      ISSUE: ;
      WAIT: begin
        if (bus.add_done) begin
          result_d = bus.add_result;
          done0_d  = grant0_q;
          done1_d  = grant1_q;
        end
      end
      RESP: begin
        grant0_d = 1'b0;
        grant1_d = 1'b0;
      end
      default: ;
    endcase
    busy_d = (state_d != IDLE);
  end

  assign bus.grant0       = grant0_q;
  assign bus.grant1       = grant1_q;
  assign bus.done0        = done0_q;
  assign bus.done1        = done1_q;
  assign bus.result       = result_q;
  assign bus.busy         = busy_q;
  assign bus.add_start    = add_start_q;
  assign bus.add_subtract = add_subtract_q;
  assign bus.add_a        = add_a_q;
  assign bus.add_b        = add_b_q;

endmodule
